button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/clock_alarm_pkg.sv | 39 +++
 rtl/debounce.sv | 62 ++++++
 rtl/button_conditioner.sv | 207 ++++++++++++++++++++
 tb/tb_button_conditioner.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_alarm_pkg.sv
// -----------------------------------------------------------------------------
// clock_alarm_pkg
// Shared definitions for the alarm-clock front panel:
//   - repeat FSM state encoding for the MIN/HR auto-repeat buttons
//   - default timing constants derived from the 5 MHz system clock
//   - button index map used by button_conditioner
//   - cnt_width(): counter width helper that never returns zero
// -----------------------------------------------------------------------------
package clock_alarm_pkg;

    // System clock coming out of the PLL.
    localparam int unsigned CLK_FREQ_HZ         = 32'd5_000_000;

    // 10 ms debounce, 0.5 s before auto-repeat, 0.2 s between repeats.
    localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_FREQ_HZ / 32'd100;
    localparam int unsigned DEF_REPEAT_DELAY    = CLK_FREQ_HZ / 32'd2;
    localparam int unsigned DEF_REPEAT_RATE     = CLK_FREQ_HZ / 32'd5;

    // Button index map; MIN and HR must stay adjacent (repeat channels loop).
    localparam int unsigned NUM_BUTTONS   = 32'd5;
    localparam int unsigned BTN_SET_CLOCK = 32'd0;
    localparam int unsigned BTN_SET_ALARM = 32'd1;
    localparam int unsigned BTN_MIN       = 32'd2;
    localparam int unsigned BTN_HR        = 32'd3;
    localparam int unsigned BTN_ALARM_OFF = 32'd4;

    // Auto-repeat FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PRESSED = 2'b01,
        REPEAT  = 2'b10
    } rep_state_e;

    // Bits needed for a counter holding 0 .. n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage : clock_alarm_pkg

// File: rtl/debounce.sv
// -----------------------------------------------------------------------------
// debounce
// One-bit button conditioner: 2-flop synchronizer followed by a stability
// counter. The accepted level only changes after the synchronized input has
// differed from it for DEBOUNCE_CYCLES consecutive cycles.
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   raw_in   in   raw button, asynchronous to clk
//   level_o  out  accepted (debounced) level, straight from a flop
// -----------------------------------------------------------------------------
module debounce
    import clock_alarm_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic level_o
);

    localparam int unsigned         CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

    logic [1:0]       sync_q,  sync_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             level_q, level_d;

    // Next-state: synchronizer shift and stability counter.
    always_comb begin
        sync_d  = {sync_q[0], raw_in};
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync_q[1] == level_q) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
            // Input has differed long enough: accept it and restart.
            cnt_d   = {CNT_W{1'b0}};
            level_d = sync_q[1];
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= 2'b00;
            cnt_q   <= {CNT_W{1'b0}};
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

endmodule : debounce

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Front-panel button conditioning for the alarm clock. Five raw push-buttons
// are each synchronized and debounced; the results drive:
//   Set_Clock, Set_Alarm  registered debounced levels
//   Alarm_Off             one-cycle pulse on each accepted press
//   MIN, HR               one-cycle increment pulses, only while Set_Clock or
//                         Set_Alarm is held; optional hold-to-repeat
//
// Configuration macro
//   BUTTON_AUTO_REPEAT_EN  defined: MIN/HR use the IDLE/PRESSED/REPEAT FSM
//                          (first pulse on press, another after REPEAT_DELAY,
//                          then every REPEAT_RATE cycles while held).
//                          undefined: one pulse per press, no repeat timers;
//                          REPEAT_DELAY/REPEAT_RATE have no effect.
//
// Ports
//   clk            in   5 MHz system clock, rising edge
//   reset          in   asynchronous active-low reset
//   *_raw          in   raw active-high buttons, asynchronous to clk
//   Set_Clock/Set_Alarm, MIN/HR, Alarm_Off  out  see above, all registered
// -----------------------------------------------------------------------------
module button_conditioner
    import clock_alarm_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic reset,
    input  logic Set_Clock_raw,
    input  logic Set_Alarm_raw,
    input  logic MIN_raw,
    input  logic HR_raw,
    input  logic Alarm_Off_raw,
    output logic Set_Clock,
    output logic Set_Alarm,
    output logic MIN,
    output logic HR,
    output logic Alarm_Off
);

    // Zero-length timings would make the counters meaningless.
    if (DEBOUNCE_CYCLES < 32'd1 || REPEAT_DELAY < 32'd1 || REPEAT_RATE < 32'd1) begin : g_bad_cfg
        $error("button_conditioner: timing parameters must be at least 1");
    end

    logic [NUM_BUTTONS-1:0] raw_s;
    logic [NUM_BUTTONS-1:0] acc_s;
    logic [1:0]             inc_pulse_s;
    logic                   setting_en_s;

    assign raw_s = {Alarm_Off_raw, HR_raw, MIN_raw, Set_Alarm_raw, Set_Clock_raw};

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_db
        debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .reset   (reset),
            .raw_in  (raw_s[i]),
            .level_o (acc_s[i])
        );
    end

    // Increment pulses are only meaningful while a time is being edited.
    assign setting_en_s = acc_s[BTN_SET_CLOCK] | acc_s[BTN_SET_ALARM];

    // Channel 0 is MIN, channel 1 is HR; each runs independently.
    for (genvar ch = 0; ch < 2; ch++) begin : g_inc
        localparam int unsigned BTN = BTN_MIN + ch;

        logic pulse_q, pulse_d;

`ifdef BUTTON_AUTO_REPEAT_EN
        localparam int unsigned      TMR_W =
            cnt_width((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
        localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY - 32'd1);
        localparam logic [TMR_W-1:0] RATE_LAST  = TMR_W'(REPEAT_RATE - 32'd1);

        rep_state_e       state_q, state_d;
        logic [TMR_W-1:0] timer_q, timer_d;
        logic             fire_s;

        // Next-state: repeat FSM; the FSM runs even when pulses are masked.
        always_comb begin
            state_d = state_q;
            timer_d = timer_q;
            fire_s  = 1'b0;
            case (state_q)
                IDLE: begin
                    timer_d = {TMR_W{1'b0}};
                    if (acc_s[BTN]) begin
                        state_d = PRESSED;
                        fire_s  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                PRESSED: begin
                    if (!acc_s[BTN]) begin
                        state_d = IDLE;
                        timer_d = {TMR_W{1'b0}};
                    end else if (timer_q == DELAY_LAST) begin
                        state_d = REPEAT;
                        timer_d = {TMR_W{1'b0}};
                        fire_s  = 1'b1;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                REPEAT: begin
                    if (!acc_s[BTN]) begin
                        state_d = IDLE;
                        timer_d = {TMR_W{1'b0}};
                    end else if (timer_q == RATE_LAST) begin
                        timer_d = {TMR_W{1'b0}};
                        fire_s  = 1'b1;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = {TMR_W{1'b0}};
                end
            endcase
            pulse_d = fire_s & setting_en_s;
        end

        // State registers for the repeat FSM and its pulse output.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= IDLE;
                timer_q <= {TMR_W{1'b0}};
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                timer_q <= timer_d;
                pulse_q <= pulse_d;
            end
        end
`else
        logic held_q, held_d;

        // Next-state: single pulse on the first cycle of each accepted press.
        always_comb begin
            if (acc_s[BTN]) begin
                held_d  = 1'b1;
                pulse_d = ~held_q & setting_en_s;
            end else begin
                held_d  = 1'b0;
                pulse_d = 1'b0;
            end
        end

        // State registers for the press flag and its pulse output.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                held_q  <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                held_q  <= held_d;
                pulse_q <= pulse_d;
            end
        end
`endif

        assign inc_pulse_s[ch] = pulse_q;
    end

    logic set_clock_q,  set_clock_d;
    logic set_alarm_q,  set_alarm_d;
    logic alarm_prev_q, alarm_prev_d;
    logic alarm_off_q,  alarm_off_d;

    // Next-state: registered levels and Alarm_Off rising-edge pulse.
    always_comb begin
        set_clock_d  = acc_s[BTN_SET_CLOCK];
        set_alarm_d  = acc_s[BTN_SET_ALARM];
        alarm_prev_d = acc_s[BTN_ALARM_OFF];
        alarm_off_d  = acc_s[BTN_ALARM_OFF] & ~alarm_prev_q;
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            set_clock_q  <= 1'b0;
            set_alarm_q  <= 1'b0;
            alarm_prev_q <= 1'b0;
            alarm_off_q  <= 1'b0;
        end else begin
            set_clock_q  <= set_clock_d;
            set_alarm_q  <= set_alarm_d;
            alarm_prev_q <= alarm_prev_d;
            alarm_off_q  <= alarm_off_d;
        end
    end

    assign Set_Clock = set_clock_q;
    assign Set_Alarm = set_alarm_q;
    assign Alarm_Off = alarm_off_q;
    assign MIN       = inc_pulse_s[0];
    assign HR        = inc_pulse_s[1];

endmodule : button_conditioner

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
// Stimulus is organised in phases, each starting with a reset. For each phase
// the raw waveforms are tabulated, a reference model derives the expected
// event times (level changes of Set_Clock/Set_Alarm, pulses of MIN/HR/
// Alarm_Off) from the button rules, and pushes them into per-output queues.
// A negedge monitor pops and checks whenever the DUT shows an event.
// Button/output index: 0 Set_Clock, 1 Set_Alarm, 2 MIN, 3 HR, 4 Alarm_Off.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int DEB  = 4;
    localparam int RD   = 10;
    localparam int RR   = 5;
    localparam int NB   = 5;
    localparam int MAXC = 160;
`ifdef BUTTON_AUTO_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic Set_Clock_raw = 1'b0, Set_Alarm_raw = 1'b0, MIN_raw = 1'b0;
    logic HR_raw = 1'b0, Alarm_Off_raw = 1'b0;
    logic Set_Clock, Set_Alarm, MIN, HR, Alarm_Off;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .Set_Clock_raw (Set_Clock_raw),
        .Set_Alarm_raw (Set_Alarm_raw),
        .MIN_raw       (MIN_raw),
        .HR_raw        (HR_raw),
        .Alarm_Off_raw (Alarm_Off_raw),
        .Set_Clock     (Set_Clock),
        .Set_Alarm     (Set_Alarm),
        .MIN           (MIN),
        .HR            (HR),
        .Alarm_Off     (Alarm_Off)
    );

    int         gcyc  = 0;
    int         total = 0;
    int         bad   = 0;
    bit         stim  [NB][MAXC];
    int         exp_q [NB][$];
    int         flips [NB][$];
    string      names [NB] = '{"Set_Clock", "Set_Alarm", "MIN", "HR", "Alarm_Off"};
    logic [4:0] prev_lv = 5'b00000;

    // Accepted level of button b after edge e (relative), from its flip list.
    function automatic bit lvl(input int b, input int e);
        int n = 0;
        for (int k = 0; k < flips[b].size(); k++)
            if (flips[b][k] <= e) n++;
        return n[0];
    endfunction

    // Reference model: raw runs -> accepted flips -> expected output events.
    task automatic build_expect(input int len, input int base);
        for (int b = 0; b < NB; b++) begin
            bit acc = 1'b0;
            int c = 0;
            flips[b].delete();
            while (c < len) begin
                bit v = stim[b][c];
                int n = 1;
                while (c + n < len && stim[b][c+n] == v) n++;
                // A run differing from the accepted level for >= DEB cycles is
                // accepted 2 (sync) + DEB cycles after it starts.
                if (v != acc && n >= DEB) begin
                    flips[b].push_back(c + 2 + DEB);
                    acc = v;
                end
                c += n;
            end
        end
        for (int b = 0; b < 2; b++)
            foreach (flips[b][k])
                if (flips[b][k] + 1 <= len) exp_q[b].push_back(base + flips[b][k] + 1);
        for (int k = 0; k < flips[4].size(); k += 2)
            if (flips[4][k] + 1 <= len) exp_q[4].push_back(base + flips[4][k] + 1);
        for (int b = 2; b < 4; b++) begin
            for (int k = 0; k < flips[b].size(); k += 2) begin
                int r    = flips[b][k];
                int f    = (k + 1 < flips[b].size()) ? flips[b][k+1] : len;
                int e    = r + 1;
                int step = RD;
                while (e <= f && e <= len) begin
                    if (lvl(0, e - 1) || lvl(1, e - 1)) exp_q[b].push_back(base + e);
                    if (!REP_EN) break;
                    e    += step;
                    step  = RR;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        gcyc++;
        #1;
    endtask

    task automatic drive(input int c);
        Set_Clock_raw = stim[0][c];
        Set_Alarm_raw = stim[1][c];
        MIN_raw       = stim[2][c];
        HR_raw        = stim[3][c];
        Alarm_Off_raw = stim[4][c];
    endtask

    task automatic clear_stim();
        for (int b = 0; b < NB; b++)
            for (int c = 0; c < MAXC; c++) stim[b][c] = 1'b0;
    endtask

    task automatic set_rng(input int b, input int lo, input int hi);
        for (int c = lo; c <= hi; c++) stim[b][c] = 1'b1;
    endtask

    task automatic random_stim(input int len);
        for (int b = 0; b < NB; b++) begin
            bit v = 1'($urandom_range(0, 1));
            int c = 0;
            while (c < len) begin
                int d = int'($urandom_range(1, 14));
                for (int i = 0; i < d && c < len; i++) begin
                    stim[b][c] = v;
                    c++;
                end
                v = ~v;
            end
        end
    endtask

    // One phase: hold reset with cycle-0 inputs applied, release, run len
    // cycles, check nothing expected is left over, then reassert reset.
    task automatic run_phase(input int len);
        int base;
        drive(0);
        repeat (3) tick();
        tick();
        base = gcyc;
        drive(0);
        #2 reset = 1'b1;
        build_expect(len, base);
        for (int c = 1; c < len; c++) begin
            tick();
            drive(c);
        end
        tick();
        @(negedge clk);
        #1;
        for (int b = 0; b < NB; b++) begin
            total++;
            if (exp_q[b].size() != 0) begin
                bad++;
                $display("FAIL missing_%s: no event seen, required one at cycle %0d",
                         names[b], exp_q[b][0]);
                exp_q[b].delete();
            end
        end
        reset = 1'b0;
    endtask

    // Monitor: outputs all zero in reset; otherwise pop and check each event.
    always @(negedge clk) begin
        logic [4:0] cur;
        cur = {Alarm_Off, HR, MIN, Set_Alarm, Set_Clock};
        if (!reset) begin
            total++;
            if (cur !== 5'b00000) begin
                bad++;
                $display("FAIL reset_outputs: got %b, required 00000", cur);
            end
            prev_lv = 5'b00000;
        end else begin
            for (int b = 0; b < NB; b++) begin
                bit ev;
                ev = (b < 2) ? (cur[b] !== prev_lv[b]) : (cur[b] === 1'b1);
                if (ev) begin
                    total++;
                    if (exp_q[b].size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_%s: event at cycle %0d, required none",
                                 names[b], gcyc);
                    end else begin
                        int t;
                        t = exp_q[b].pop_front();
                        if (t != gcyc) begin
                            bad++;
                            $display("FAIL event_%s: seen at cycle %0d, required cycle %0d",
                                     names[b], gcyc, t);
                        end
                    end
                end
            end
            prev_lv = cur;
        end
    end

    initial begin
        #1 reset = 1'b0;

        // All buttons held through reset and after release.
        clear_stim();
        for (int b = 0; b < NB; b++) set_rng(b, 0, 19);
        run_phase(20);

        // Alarm_Off: 3-cycle glitch, then a 10-cycle press.
        clear_stim();
        set_rng(4, 2, 4);
        set_rng(4, 20, 29);
        run_phase(45);

        // Set_Clock held, MIN held 40 cycles.
        clear_stim();
        set_rng(0, 0, 79);
        set_rng(2, 10, 49);
        run_phase(80);

        // No setting mode: HR held 40 cycles must stay silent.
        clear_stim();
        set_rng(3, 5, 44);
        run_phase(60);

        // Reset at cycle 15 of a MIN hold, button kept held through release.
        clear_stim();
        set_rng(1, 0, 14);
        set_rng(2, 0, 14);
        run_phase(15);
        clear_stim();
        set_rng(1, 0, 59);
        set_rng(2, 0, 59);
        run_phase(70);

        // MIN and HR held together.
        clear_stim();
        set_rng(0, 0, 69);
        set_rng(2, 3, 50);
        set_rng(3, 3, 50);
        run_phase(70);

        // Random bouncing on all buttons.
        for (int p = 0; p < 8; p++) begin
            clear_stim();
            random_stim(120);
            run_phase(120);
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_button_conditioner
